flash_reader: RTL and testbench

- Bus master sitting directly upstream of the SPI flash slave; converts a "read N words from address A" job into a sequence of single-word bus read cycles.
- Handles the slave's retry (flash busy) termination with a timed back-off and a bounded retry count.
- Buffers returned words in a small FIFO and presents them as a valid/ready stream to the MIDI patch/sample consumers.

---
 rtl/flash_reader_pkg.sv | 10 +
 rtl/flash_reader_if.sv | 13 +
 rtl/flash_reader_sync_fifo.sv | 40 ++++
 rtl/flash_reader.sv | 93 +++++++++
 tb/tb_flash_reader.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/flash_reader_pkg.sv
// flash_pkg: shared widths, FSM states and SPI flash command bytes
package flash_pkg;
  localparam int ADR_W = 24;
  localparam int DAT_W = 32;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_WREN      = 8'h06;
  typedef enum logic [1:0] {IDLE, REQ, GAP, BACKOFF} state_t;
endpackage

// File: rtl/flash_reader_if.sv
// flash_reader_if: single-word bus between the reader (master) and the SPI flash slave
interface flash_reader_if;
  import flash_pkg::*;
  logic [ADR_W-1:0] adr_o;
  logic [DAT_W-1:0] dat_o;
  logic             we_o;
  logic             stb_o;
  logic [DAT_W-1:0] dat_i;
  logic             ack_i;
  logic             rty_i;
  modport master (output adr_o, dat_o, we_o, stb_o, input dat_i, ack_i, rty_i);
  modport slave  (input adr_o, dat_o, we_o, stb_o, output dat_i, ack_i, rty_i);
endinterface

// File: rtl/flash_reader_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign level   = cnt;
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= do_push ? wp + 1'b1 : wp;
      rp  <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/flash_reader.sv
// flash_reader: turns "read N words from A" into retried single-word bus reads feeding a stream FIFO
module flash_reader
  import flash_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RETRY_GAP  = 16,
  parameter int MAX_RETRY  = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ADR_W-1:0]              base_adr_i,
  input  logic [15:0]                   words_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  flash_reader_if.master                bus,
  output logic [DAT_W-1:0]              data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam logic [15:0] GAP_LD = 16'(RETRY_GAP - 1);
  localparam logic [15:0] MAX_R  = 16'(MAX_RETRY);
  state_t state;
  logic [ADR_W-1:0] adr;
  logic [15:0] cnt, rty_cnt, tmr;
  logic stb, full, empty;
  assign bus.adr_o = adr;
  assign bus.stb_o = stb;
  assign bus.dat_o = '0;
  assign bus.we_o  = 1'b0;
  assign busy_o    = state != IDLE;
  assign valid_o   = !empty;
  sync_fifo #(.WIDTH(DAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_i), .rst(rst_i), .push(stb && bus.ack_i), .pop(valid_o && ready_i),
    .din(bus.dat_i), .dout(data_o), .full(full), .empty(empty), .level(level_o)
  );
  // stb only rises with room in the FIFO, so at most one word is ever in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      adr     <= '0;
      cnt     <= '0;
      rty_cnt <= '0;
      tmr     <= '0;
      stb     <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          err_o   <= 1'b0;
          rty_cnt <= '0;
          adr     <= base_adr_i;
          cnt     <= words_i;
          if (words_i == '0) done_o <= 1'b1;
          else begin
            state <= REQ;
            stb   <= !full;
          end
        end
        REQ: if (!stb) stb <= !full;
        else if (bus.ack_i) begin
          stb     <= 1'b0;
          adr     <= adr + 24'd4;
          cnt     <= cnt - 16'd1;
          rty_cnt <= '0;
          state   <= cnt == 16'd1 ? IDLE : GAP;
          done_o  <= cnt == 16'd1;
        end else if (bus.rty_i) begin
          stb     <= 1'b0;
          rty_cnt <= rty_cnt + 16'd1;
          tmr     <= GAP_LD;
          if (MAX_RETRY != 0 && rty_cnt + 16'd1 == MAX_R) begin
            state <= IDLE;
            err_o <= 1'b1;
          end else state <= BACKOFF;
        end
        GAP: begin
          state <= REQ;
          stb   <= !full;
        end
        BACKOFF: if (tmr == '0) begin
          state <= REQ;
          stb   <= !full;
        end else tmr <= tmr - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader: table-driven jobs against a latency/retry slave model with data scoreboard
module tb_flash_reader;
  logic clk, rst_i, start_i, ready_i;
  logic [23:0] base_adr_i;
  logic [15:0] words_i;
  logic busy_o, done_o, err_o, valid_o;
  logic [31:0] data_o;
  logic [2:0] level_o;
  flash_reader_if bus();
  flash_reader #(.FIFO_DEPTH(4), .RETRY_GAP(16), .MAX_RETRY(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_adr_i(base_adr_i), .words_i(words_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [23:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  int gaps_q[$];
  int rty_cfg = 0, lat_cfg = 5, rty_left = 0, done_cnt = 0, stb_cnt = 0;
  bit both_cfg = 0, counting = 0;
  typedef struct {
    logic [23:0] base; logic [15:0] words; int rty; bit both; int lat;
    int exp_done; bit exp_err; int exp_gap; int exp_stb;
  } vec_t;
  vec_t vecs[7];
  function automatic logic [31:0] dfun(logic [23:0] a);
    return {~a[7:0], a};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // slave model: terminates each strobe after lat_cfg cycles, retrying rty_cfg times per word
  initial begin
    int wt, low;
    logic [23:0] cur;
    bus.ack_i = 0; bus.rty_i = 0; bus.dat_i = '0;
    wt = 0; low = 0; cur = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_i) begin
        bus.ack_i = 0; bus.rty_i = 0; wt = 0; counting = 0;
        continue;
      end
      if (done_o) done_cnt++;
      if (bus.ack_i || bus.rty_i) begin
        chk("stb_drop", bus.stb_o, 0);
        if (bus.ack_i) chk("valid_lat", valid_o, 1);
        bus.ack_i = 0; bus.rty_i = 0; wt = 0; counting = 1; low = 0;
      end
      if (!busy_o) chk("stb_idle", bus.stb_o, 0);
      if (counting) begin
        if (!bus.stb_o) low++;
        else begin gaps_q.push_back(low); counting = 0; end
      end
      if (bus.stb_o) begin
        if (wt == 0) begin
          stb_cnt++;
          cur = bus.adr_o;
          chk("adr", bus.adr_o, exp_adr_q.size() != 0 ? exp_adr_q[0] : 24'hDEAD00);
        end else chk("adr_stable", bus.adr_o, cur);
        if (wt == lat_cfg) begin
          chk("no_push_full", level_o < 3'd4, 1);
          if (both_cfg || rty_left == 0) begin
            bus.ack_i = 1; bus.rty_i = both_cfg; bus.dat_i = dfun(bus.adr_o);
            if (exp_adr_q.size() != 0) void'(exp_adr_q.pop_front());
            rty_left = rty_cfg;
          end else begin
            bus.rty_i = 1; rty_left--;
          end
        end else wt++;
      end else wt = 0;
    end
  end
  // stream consumer: pops the scoreboard on each transfer, checks head stability under backpressure
  initial begin
    bit hold = 0;
    logic [31:0] last = '0;
    forever begin
      @(negedge clk); #2;
      if (rst_i) begin hold = 0; continue; end
      if (valid_o && ready_i) begin
        if (exp_dat_q.size() == 0) chk("unexpected_word", data_o, 32'hXXXX_XXXX);
        else chk("data", data_o, exp_dat_q.pop_front());
      end
      if (valid_o && !ready_i) begin
        if (hold) chk("data_hold", data_o, last);
        hold = 1; last = data_o;
      end else hold = 0;
    end
  end
  task automatic run_job(input logic [23:0] base, input logic [15:0] n, input bit no_data);
    @(negedge clk);
    base_adr_i = base; words_i = n; start_i = 1;
    done_cnt = 0; stb_cnt = 0; gaps_q.delete(); counting = 0; rty_left = rty_cfg;
    for (int i = 0; i < int'(n); i++) begin
      exp_adr_q.push_back(base + 24'(4 * i));
      if (!no_data) exp_dat_q.push_back(dfun(base + 24'(4 * i)));
    end
    @(negedge clk);
    start_i = 0;
    chk("err_clr", err_o, 0);
    if (n != 0) begin
      chk("start_lat", bus.stb_o, 1);
      chk("busy", busy_o, 1);
    end else begin
      chk("done_zero", done_o, 1);
      chk("stb_zero", bus.stb_o, 0);
      chk("busy_zero", busy_o, 0);
    end
  endtask
  task automatic finish_job();
    int k = 0;
    while (busy_o && k < 3000) begin @(negedge clk); k++; end
    chk("idle_timeout", busy_o, 0);
    k = 0;
    while ((exp_dat_q.size() != 0 || valid_o) && k < 3000) begin @(negedge clk); k++; end
    chk("drain", exp_dat_q.size(), 0);
    chk("level_end", level_o, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{24'h000100, 16'd3, 0,    0, 20, 1, 0, 1,  3};
    vecs[1] = '{24'h000200, 16'd1, 2,    0, 20, 1, 0, 16, 3};
    vecs[2] = '{24'hFFFFFC, 16'd2, 0,    0, 5,  1, 0, 1,  2};
    vecs[3] = '{24'h000300, 16'd2, 0,    1, 5,  1, 0, 1,  2};
    vecs[4] = '{24'h000400, 16'd0, 0,    0, 5,  1, 0, -1, 0};
    vecs[5] = '{24'h000500, 16'd2, 1000, 0, 4,  0, 1, 16, 3};
    vecs[6] = '{24'h000600, 16'd3, 1,    0, 4,  1, 0, -1, 6};
    rst_i = 1; start_i = 0; ready_i = 1; base_adr_i = '0; words_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("we_zero", bus.we_o, 0);
    chk("dat_zero", bus.dat_o, 0);
    rst_i = 0;
    foreach (vecs[v]) begin
      rty_cfg = vecs[v].rty; both_cfg = vecs[v].both; lat_cfg = vecs[v].lat;
      run_job(vecs[v].base, vecs[v].words, vecs[v].exp_err);
      finish_job();
      chk($sformatf("done_cnt[%0d]", v), done_cnt, vecs[v].exp_done);
      chk($sformatf("err[%0d]", v), err_o, 32'(vecs[v].exp_err));
      chk($sformatf("stb_cnt[%0d]", v), stb_cnt, vecs[v].exp_stb);
      if (vecs[v].exp_gap >= 0)
        foreach (gaps_q[g]) chk($sformatf("gap[%0d]", v), gaps_q[g], vecs[v].exp_gap);
      if (vecs[v].exp_err) exp_adr_q.delete();
      chk($sformatf("adr_left[%0d]", v), exp_adr_q.size(), 0);
    end
    // backpressure: FIFO fills, fetching stalls, then resumes in order
    rty_cfg = 0; both_cfg = 0; lat_cfg = 5; ready_i = 0;
    run_job(24'h000700, 16'd8, 0);
    repeat (200) @(negedge clk);
    chk("bp_level", level_o, 4);
    chk("bp_stb", bus.stb_o, 0);
    chk("bp_fetched", stb_cnt, 4);
    chk("bp_busy", busy_o, 1);
    ready_i = 1;
    finish_job();
    chk("bp_done", done_cnt, 1);
    chk("bp_total", stb_cnt, 8);
    // reset while the second word is on the bus
    ready_i = 0;
    run_job(24'h000800, 16'd4, 0);
    begin
      int k = 0;
      while (!(stb_cnt >= 2 && bus.stb_o) && k < 500) begin @(negedge clk); k++; end
    end
    chk("mid_stb", bus.stb_o, 1);
    chk("mid_level", level_o, 1);
    rst_i = 1;
    @(negedge clk);
    chk("mid_rst_stb", bus.stb_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_level", level_o, 0);
    rst_i = 0;
    exp_adr_q.delete(); exp_dat_q.delete();
    ready_i = 1;
    run_job(24'h000900, 16'd2, 0);
    finish_job();
    chk("post_rst_done", done_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
